// File: rtl/poly_decim.sv
`default_nettype none
// ============================================================================
// Module   : poly_decim
// Purpose  : Polyphase FIR decimator. Keeps the full tap history, snapshots it
//            on every rate-th sample and runs a time-multiplexed MAC
//            (rate products per clock, m_len clocks per output). The result is
//            scaled by 2^-(width-1), saturated and strobed out on cke_out.
// Revision : 1.0 - initial release
// ============================================================================
module poly_decim #(
    parameter int rate    = 2,
    parameter int tap_len = 8,
    parameter int m_len   = (tap_len + rate - 1) / rate,
    parameter int width   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cke,
    input  logic signed [width-1:0]       din,
    input  logic [tap_len-1:0][width-1:0] tap,
    output logic signed [width-1:0]       dout,
    output logic                          cke_out,
    output logic                          ovf
);

    localparam int N  = m_len * rate;
    localparam int AW = 2 * width + $clog2(N);
    localparam int PW = (rate > 1) ? $clog2(rate) : 1;
    localparam int JW = (m_len > 1) ? $clog2(m_len) : 1;

    localparam logic [PW-1:0] PH_LAST = PW'(rate - 1);
    localparam logic [JW-1:0] J_LAST  = JW'(m_len - 1);

    localparam logic signed [AW-1:0] MAX_V = {{(AW - width + 1){1'b0}}, {(width - 1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW - width + 1){1'b1}}, {(width - 1){1'b0}}};

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MAC  = 1'b1;

    logic [0:0]                 state;
    logic [0:0]                 state_nxt;
    logic [N-1:0][width-1:0]    sr;
    logic [N-1:0][width-1:0]    sr_nxt;
    logic [N-1:0][width-1:0]    snap;
    logic [N-1:0][width-1:0]    coef;
    logic signed [2*width-1:0]  prod [N];
    logic signed [AW-1:0]       gsum [m_len];
    logic signed [AW-1:0]       acc;
    logic signed [AW-1:0]       acc_sum;
    logic signed [AW-1:0]       scaled;
    logic signed [width-1:0]    sat;
    logic [PW-1:0]              ph;
    logic [JW-1:0]              j;
    logic                       frame;
    logic                       mac_en;
    logic                       start;
    logic                       finish;
    logic                       drop;

    // History after accepting the current sample, newest at index 0
    assign sr_nxt = {sr[N-2:0], din};
    assign frame  = cke && (ph == PH_LAST);

    // Coefficients beyond tap_len read as zero; one product per history slot
    for (genvar i = 0; i < N; i++) begin : g_coef
        if (i < tap_len) begin : g_tap
            assign coef[i] = tap[i];
        end else begin : g_pad
            assign coef[i] = '0;
        end
        assign prod[i] = $signed({{width{snap[i][width-1]}}, snap[i]})
                       * $signed({{width{coef[i][width-1]}}, coef[i]});
    end

    // Sum of the rate products belonging to each MAC group
    always_comb begin
        for (int g = 0; g < m_len; g++) begin
            gsum[g] = '0;
            for (int r = 0; r < rate; r++) begin
                gsum[g] = gsum[g]
                        + {{(AW - 2*width){prod[g*rate + r][2*width-1]}}, prod[g*rate + r]};
            end
        end
    end

    assign acc_sum = acc + gsum[j];
    assign scaled  = acc_sum >>> (width - 1);

    // Clamp the scaled sum into the output range
    always_comb begin
        if (scaled > MAX_V) begin
            sat = MAX_V[width-1:0];
        end else if (scaled < MIN_V) begin
            sat = MIN_V[width-1:0];
        end else begin
            sat = scaled[width-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: start on a frame strobe, finish after the last group
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frame) state_nxt = S_MAC;
            S_MAC:   if (j == J_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: control strobes for the datapath
    always_comb begin
        mac_en = (state == S_MAC);
        start  = (state == S_IDLE) && frame;
        finish = mac_en && (j == J_LAST);
        drop   = mac_en && frame;
    end

    // History shift register and phase counter advance on every sample
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
            ph <= '0;
        end else if (cke) begin
            sr <= sr_nxt;
            ph <= frame ? '0 : ph + 1'b1;
        end
    end

    // MAC datapath: snapshot on start, accumulate one group per clock
    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
            acc  <= '0;
            j    <= '0;
        end else if (start) begin
            snap <= sr_nxt;
            acc  <= '0;
            j    <= '0;
        end else if (mac_en) begin
            acc <= acc_sum;
            j   <= finish ? '0 : j + 1'b1;
        end
    end

    // Output register and one-cycle status strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= '0;
            cke_out <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            cke_out <= finish;
            ovf     <= drop;
            if (finish) begin
                dout <= sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_decim
// Purpose  : Directed self-checking bench for poly_decim. One instance with
//            rate=4 (m_len=2) and one with rate=2 (m_len=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_decim;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cke4 = 1'b0;
    logic [15:0]       din4 = '0;
    logic [7:0][15:0]  tap4 = '0;
    logic [15:0]       dout4;
    logic              co4;
    logic              ovf4;
    logic              cke2 = 1'b0;
    logic [15:0]       din2 = '0;
    logic [7:0][15:0]  tap2 = '0;
    logic [15:0]       dout2;
    logic              co2;
    logic              ovf2;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] hist [8];
    logic signed [15:0] tv   [8];

    always #5 clk = ~clk;

    poly_decim #(.rate(4), .tap_len(8), .width(16)) dut4 (
        .clk(clk), .rst(rst), .cke(cke4), .din(din4), .tap(tap4),
        .dout(dout4), .cke_out(co4), .ovf(ovf4)
    );

    poly_decim #(.rate(2), .tap_len(8), .width(16)) dut2 (
        .clk(clk), .rst(rst), .cke(cke2), .din(din2), .tap(tap2),
        .dout(dout2), .cke_out(co2), .ovf(ovf2)
    );

    // Reference: full 8-tap dot product, arithmetic shift, saturation
    function automatic logic [15:0] ref_dec();
        longint a = 0;
        for (int k = 0; k < 8; k++) a += longint'(hist[k]) * longint'(tv[k]);
        a = a >>> 15;
        if (a > 32767) return 16'h7FFF;
        if (a < -32768) return 16'h8000;
        return a[15:0];
    endfunction

    task automatic hpush(input logic [15:0] d);
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
    endtask

    task automatic hclear();
        for (int k = 0; k < 8; k++) hist[k] = '0;
    endtask

    // One clock on the rate-4 instance; outputs are stable #1 after the edge
    task automatic tick4(input logic c, input logic [15:0] d);
        cke4 = c;
        din4 = d;
        @(posedge clk);
        #1;
        cke4 = 1'b0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        cke4 = 1'b0;
        cke2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        cke4 = 1'b1;
        din4 = 16'h7FFF;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dout4 !== 16'h0) begin errors++; $display("FAIL reset dout4: got %h expected 0000", dout4); end
        checks++; if (co4 !== 1'b0) begin errors++; $display("FAIL reset cke_out4: got %b expected 0", co4); end
        checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL reset ovf4: got %b expected 0", ovf4); end
        checks++; if (dout2 !== 16'h0) begin errors++; $display("FAIL reset dout2: got %h expected 0000", dout2); end
        checks++; if (co2 !== 1'b0) begin errors++; $display("FAIL reset cke_out2: got %b expected 0", co2); end
        checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL reset ovf2: got %b expected 0", ovf2); end
        cke4 = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic test_dc_gain();
        logic [15:0] exp_v;
        for (int k = 0; k < 8; k++) tap4[k] = 16'h4000;
        do_reset();
        for (int s = 1; s <= 12; s++) begin
            tick4(1'b1, 16'h1000);
            checks++; if (co4 !== 1'b0 || ovf4 !== 1'b0) begin errors++; $display("FAIL dc_gain strobe s=%0d: cke_out=%b ovf=%b expected 0 0", s, co4, ovf4); end
            tick4(1'b0, 16'h0);
            checks++; if (co4 !== 1'b0) begin errors++; $display("FAIL dc_gain E1 s=%0d: cke_out=%b expected 0", s, co4); end
            tick4(1'b0, 16'h0);
            exp_v = (s == 4) ? 16'h2000 : 16'h4000;
            checks++;
            if (s % 4 == 0) begin
                if (co4 !== 1'b1 || dout4 !== exp_v) begin errors++; $display("FAIL dc_gain out s=%0d: cke_out=%b dout=%h expected 1 %h", s, co4, dout4, exp_v); end
            end else if (co4 !== 1'b0) begin
                errors++; $display("FAIL dc_gain idle s=%0d: cke_out=%b expected 0", s, co4);
            end
        end
    endtask

    task automatic test_impulse();
        logic [15:0] exp_v;
        for (int k = 0; k < 8; k++) tap4[k] = 16'((k + 1) * 16'h0800);
        do_reset();
        for (int s = 1; s <= 12; s++) begin
            tick4(1'b1, (s == 1) ? 16'h4000 : 16'h0000);
            checks++; if (co4 !== 1'b0) begin errors++; $display("FAIL impulse strobe s=%0d: cke_out=%b expected 0", s, co4); end
            tick4(1'b0, 16'h0);
            tick4(1'b0, 16'h0);
            exp_v = (s == 4) ? 16'h1000 : (s == 8) ? 16'h2000 : 16'h0000;
            checks++;
            if (s % 4 == 0) begin
                if (co4 !== 1'b1 || dout4 !== exp_v) begin errors++; $display("FAIL impulse out s=%0d: cke_out=%b dout=%h expected 1 %h", s, co4, dout4, exp_v); end
            end else if (co4 !== 1'b0) begin
                errors++; $display("FAIL impulse early s=%0d: cke_out=%b expected 0", s, co4);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        logic [15:0] exp_v;
        for (int k = 0; k < 8; k++) tap4[k] = 16'h4000;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            d = (p == 0) ? 16'h2000 : 16'h8000;
            for (int s = 1; s <= 12; s++) begin
                tick4(1'b1, d);
                tick4(1'b0, 16'h0);
                tick4(1'b0, 16'h0);
                if (s % 4 == 0) begin
                    exp_v = (p == 1) ? 16'h8000 : (s == 4) ? 16'h4000 : 16'h7FFF;
                    checks++; if (co4 !== 1'b1 || dout4 !== exp_v) begin errors++; $display("FAIL saturation p=%0d s=%0d: cke_out=%b dout=%h expected 1 %h", p, s, co4, dout4, exp_v); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        for (int k = 0; k < 8; k++) tap4[k] = 16'h4000;
        do_reset();
        for (int s = 1; s <= 3; s++) begin
            tick4(1'b1, 16'h1000);
            tick4(1'b0, 16'h0);
        end
        tick4(1'b1, 16'h1000);
        rst = 1'b1;
        tick4(1'b0, 16'h0);
        rst = 1'b0;
        checks++; if (dout4 !== 16'h0 || co4 !== 1'b0) begin errors++; $display("FAIL rst_mid reset: dout=%h cke_out=%b expected 0000 0", dout4, co4); end
        for (int t = 0; t < 3; t++) begin
            tick4(1'b0, 16'h0);
            checks++; if (co4 !== 1'b0 || dout4 !== 16'h0) begin errors++; $display("FAIL rst_mid abort t=%0d: cke_out=%b dout=%h expected 0 0000", t, co4, dout4); end
        end
        for (int s = 1; s <= 4; s++) begin
            tick4(1'b1, 16'h0800);
            tick4(1'b0, 16'h0);
            tick4(1'b0, 16'h0);
            checks++;
            if (s == 4) begin
                if (co4 !== 1'b1 || dout4 !== 16'h1000) begin errors++; $display("FAIL rst_mid first_out: cke_out=%b dout=%h expected 1 1000", co4, dout4); end
            end else if (co4 !== 1'b0) begin
                errors++; $display("FAIL rst_mid early s=%0d: cke_out=%b expected 0", s, co4);
            end
        end
    endtask

    task automatic test_overrun();
        logic [15:0] d;
        logic [15:0] pend_v = '0;
        logic        exp_co;
        logic        exp_ovf;
        for (int k = 0; k < 8; k++) begin
            tv[k]   = 16'($urandom);
            tap2[k] = tv[k];
        end
        do_reset();
        hclear();
        for (int n = 1; n <= 20; n++) begin
            d    = 16'($urandom);
            cke2 = 1'b1;
            din2 = d;
            @(posedge clk);
            #1;
            hpush(d);
            exp_co  = (n >= 6) && (n % 6 == 0);
            exp_ovf = (n >= 4) && ((n % 6 == 4) || (n % 6 == 0));
            checks++; if (co2 !== exp_co) begin errors++; $display("FAIL overrun cke_out edge=%0d: got %b expected %b", n, co2, exp_co); end
            checks++; if (ovf2 !== exp_ovf) begin errors++; $display("FAIL overrun ovf edge=%0d: got %b expected %b", n, ovf2, exp_ovf); end
            if (exp_co) begin
                checks++; if (dout2 !== pend_v) begin errors++; $display("FAIL overrun dout edge=%0d: got %h expected %h", n, dout2, pend_v); end
            end
            if (n % 6 == 2) pend_v = ref_dec();
        end
        cke2 = 1'b0;
    endtask

    task automatic test_gapped();
        logic [15:0] d;
        logic [15:0] exp_v = '0;
        logic        exp_co;
        int          pend = 0;
        int          gap;
        for (int k = 0; k < 8; k++) begin
            tv[k]   = 16'($urandom);
            tap4[k] = tv[k];
        end
        do_reset();
        hclear();
        for (int s = 1; s <= 40; s++) begin
            d   = 16'($urandom);
            gap = (s == 40) ? 3 : $urandom_range(0, 2);
            for (int t = 0; t <= gap; t++) begin
                tick4(t == 0, d);
                if (t == 0) hpush(d);
                if (t == 0 && s % 4 == 0) begin
                    pend   = 2;
                    exp_v  = ref_dec();
                    exp_co = 1'b0;
                end else if (pend > 0) begin
                    pend--;
                    exp_co = (pend == 0);
                end else begin
                    exp_co = 1'b0;
                end
                checks++; if (co4 !== exp_co || ovf4 !== 1'b0) begin errors++; $display("FAIL gapped strobe s=%0d t=%0d: cke_out=%b ovf=%b expected %b 0", s, t, co4, ovf4, exp_co); end
                if (exp_co) begin
                    checks++; if (dout4 !== exp_v) begin errors++; $display("FAIL gapped dout s=%0d: got %h expected %h", s, dout4, exp_v); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dc_gain();
        test_impulse();
        test_saturation();
        test_reset_mid_mac();
        test_overrun();
        test_gapped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/poly_decim.md
# poly_decim

Polyphase FIR decimator, the receive-side counterpart of the polyphase interpolator in the DSP chain. It consumes one input sample per `cke` strobe and keeps the full tap history. On every `rate`-th accepted sample it snapshots that history and computes one output with a time-multiplexed MAC, `rate` products per clock over `m_len` clocks. The result is scaled, saturated and presented with a one-cycle `cke_out` strobe.

## Interface
- `rate`, 2: decimation factor, ≥1.
- `tap_len`, 8: number of FIR coefficients, ≥2.
- `m_len`, (tap_len+rate-1)/rate: MAC cycles per output.
- `width`, 16: sample and coefficient width, signed Q1.(width-1).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cke`  in  1  input sample strobe; `din` is valid when high.
- `din`  in  width  signed input sample.
- `tap`  in  tap_len×width  packed signed coefficients. `tap[k]` weights the sample k strobes older than the newest. Static during operation.
- `dout`  out  width  signed decimated output, registered.
- `cke_out`  out  1  one-cycle pulse when a new `dout` is loaded.
- `ovf`  out  1  one-cycle pulse when a frame is dropped because the MAC is busy.

## Operation
- History shift register `sr[0..m_len*rate-1]`, newest at index 0. It shifts on every `cke`, regardless of MAC state.
- Phase counter `ph` runs 0..rate-1:
  - Increments on each `cke`.
  - Wraps to 0 on a `cke` that arrives when `ph==rate-1`. That strobe is the frame strobe.
- Coefficients with index ≥ `tap_len` read as 0. This zero-pads the last phase when `m_len*rate > tap_len`.
- FSM states:
  - IDLE → MAC on a frame strobe. At the same edge:
    - `snap` is loaded with the post-shift history, i.e. including this `din`.
    - `acc` is set to 0.
    - `j` is set to 0.
  - MAC, for j = 0..m_len-1, one group per clock: `acc += Σ_{r=0..rate-1} snap[j*rate+r]*tap[j*rate+r]`.
  - MAC → IDLE at the edge where `j==m_len-1`. At that same edge:
    - `dout` is loaded from the final sum.
    - `cke_out` is set to 1.
- Frame strobe while in MAC (including its final edge):
  - The frame is dropped and `ovf` pulses for one cycle.
  - `snap` and `acc` are untouched.
  - `sr` and `ph` still advance normally.
- Arithmetic:
  - Each product is 2·width bits.
  - `acc` is 2·width+clog2(m_len·rate) bits, signed; it never wraps.
  - Output = `acc >>> (width-1)`, arithmetic shift (truncation toward −∞), then saturated to [−2^(width-1), 2^(width-1)−1].
- Non-frame `cke` strobes and idle cycles have no effect on `dout`; it holds its last value.

## Timing
- Reset values: `dout`=0, `cke_out`=0, `ovf`=0, `sr`=0, `snap`=0, `acc`=0, `ph`=0, `j`=0, state IDLE.
- A reset asserted mid-MAC aborts the computation: no `cke_out` is produced, and the next frame needs `rate` fresh strobes.
- Latency:
  - Frame strobe sampled at edge E0.
  - MAC accumulates at edges E1..E(m_len).
  - `dout`/`cke_out` are updated at edge E(m_len).
  - `cke_out` is high for the single cycle following E(m_len).
- Minimum frame spacing without loss is m_len+1 clocks. `cke` itself has no spacing restriction.
- `ovf` is high for the cycle following the edge at which the dropped frame strobe was sampled.
- `cke_out` and `ovf` can be high in the same cycle.

## Test plan
Unless stated otherwise, tests use `width`=16, `rate`=4, `tap_len`=8, `m_len`=2.

- **DC gain.** Stimulus: all taps 0x4000; `din`=0x1000 on every strobe; `cke` every 3rd clock; at least 8 strobes of history. Required: each `cke_out` carries `dout`=0x4000, with `cke_out` exactly 2 clocks after each frame strobe edge.
- **Impulse / phase alignment.** Stimulus: `tap[k]`=0x0800·(k+1); `din`=0x4000 on the first strobe after reset, 0 thereafter. Required:
  - 1st output 0x1000.
  - 2nd output 0x2000.
  - 3rd and later outputs 0x0000.
  - No output before the 4th strobe.
- **Saturation.** All taps 0x4000:
  - Constant `din`=0x2000 → `dout`=0x7FFF.
  - Constant `din`=0x8000 → `dout`=0x8000.
- **Overrun.** Stimulus: `rate`=2, `tap_len`=8 (`m_len`=4); `cke` high continuously from reset. Required:
  - The first frame (edge 2) is accepted.
  - Frames at edges 4 and 6 are dropped, with `ovf` pulses after those edges.
  - The frame at edge 8 is accepted.
  - Each `cke_out` matches a reference computed only on the accepted frames.
- **Reset mid-MAC.** Stimulus: assert `rst` for 1 clock on the clock after a frame strobe. Required:
  - No `cke_out` for that frame.
  - `dout`=0.
  - After release, the first `cke_out` occurs only after 4 new strobes, and its value is computed from post-reset history (zeros before the new samples).
- **Gapped input.** Stimulus: random `cke` pattern (≥3 clocks between frames), random `din`/taps. Required: every `dout` bit-exactly matches the scaled, saturated reference decimator; `ovf` never asserts.
